// File: rtl/led_blink_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_blink_seq_pkg
// Brief   : Shared widths, FSM state encoding and the divider clamp helper
//           for the LED blink sequencer.
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
package led_blink_seq_pkg;

  // Command field widths
  localparam int CNT_FIELD_W = 4;
  localparam int DIV_FIELD_W = 5;
  localparam int PWM_W       = 4;

  // Wide enough to hold div_eff+1 for any 5-bit divider (max 32)
  localparam int SHIFT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_e;

  // Plain-vector state constants so the FSM register stays a simple logic [1:0]
  localparam logic [1:0] c_ST_IDLE = ST_IDLE;
  localparam logic [1:0] c_ST_ON   = ST_ON;
  localparam logic [1:0] c_ST_OFF  = ST_OFF;
  localparam logic [1:0] c_ST_GAP  = ST_GAP;

  // Clamp the requested divider so the tick mask never exceeds the counter
  function automatic logic [SHIFT_W-1:0] f_div_eff(
    input logic [DIV_FIELD_W-1:0] div,
    input logic [SHIFT_W-1:0]     div_max
  );
    logic [SHIFT_W-1:0] d;
    d = SHIFT_W'(div);
    return (d > div_max) ? div_max : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : led_prescaler
// Brief   : Free-running prescaler with synchronous clear. Produces a tick
//           once every 2^(div_eff+1) cycles, where div_eff is the requested
//           divider clamped to PRESCALE_W-1, and exposes the low counter bits
//           as a PWM phase.
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
module led_prescaler
  import led_blink_seq_pkg::*;
#(
  parameter int PRESCALE_W = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic [DIV_FIELD_W-1:0] i_div,
  output logic [PWM_W-1:0]       o_phase,
  output logic                   o_tick
);

  // Largest usable divider: the mask may cover the whole counter, no more
  localparam logic [SHIFT_W-1:0] c_DIV_MAX =
    (PRESCALE_W - 1 > 31) ? SHIFT_W'(31) : SHIFT_W'(PRESCALE_W - 1);

  logic [PRESCALE_W-1:0] r_count;
  logic [SHIFT_W-1:0]    w_div_eff;
  logic [SHIFT_W-1:0]    w_shamt;
  logic [PRESCALE_W-1:0] w_mask;

  // Counter runs every cycle and wraps naturally; clear aligns phase to accept
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + PRESCALE_W'(1);
    end
  end

  // mask = 2^(div_eff+1)-1; a shift of PRESCALE_W yields an all-ones mask
  always_comb begin
    w_div_eff = f_div_eff(i_div, c_DIV_MAX);
    w_shamt   = w_div_eff + SHIFT_W'(1);
    w_mask    = ~({PRESCALE_W{1'b1}} << w_shamt);
  end

  assign o_tick  = ((r_count & w_mask) == w_mask);
  assign o_phase = r_count[PWM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/led_blink_seq.sv
`default_nettype none
// ============================================================================
// Module  : led_blink_seq
// Brief   : Command-driven LED blink sequencer. Accepts one command at a time
//           over a valid/ready handshake, blinks the LED count times with
//           ON/OFF phases of 2^(div_eff+1) cycles, optionally repeats bursts
//           separated by a GAP_TICKS-tick gap, and supports abort.
// Macros  : LED_BLINK_SEQ_DIM_EN - PWM-dim the LED during ON using the
//           latched brightness; when undefined cmd_bright is ignored.
// Revision: 1.0 - initial release
// ============================================================================
module led_blink_seq
  import led_blink_seq_pkg::*;
#(
  parameter int PRESCALE_W = 26,
  parameter int GAP_TICKS  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CNT_FIELD_W-1:0] cmd_count,
  input  logic [DIV_FIELD_W-1:0] cmd_div,
  input  logic                   cmd_loop,
  input  logic [PWM_W-1:0]       cmd_bright,
  input  logic                   abort,
  output logic                   led,
  output logic                   busy,
  output logic                   done
);

  localparam int c_GAP_W = $clog2(GAP_TICKS + 1);

  // FSM and latched command
  logic [1:0]             r_state;
  logic [CNT_FIELD_W-1:0] r_remaining;
  logic [c_GAP_W-1:0]     r_gap;
  logic [CNT_FIELD_W-1:0] r_cnt_lat;
  logic [DIV_FIELD_W-1:0] r_div_lat;
  logic                   r_loop_lat;
  logic                   r_done;

  // Handshake and tick
  logic                   w_idle;
  logic                   w_accept;
  logic                   w_abort_run;
  logic                   w_tick;
  logic [PWM_W-1:0]       w_phase;
  logic [CNT_FIELD_W-1:0] w_rem_dec;
  logic [c_GAP_W-1:0]     w_gap_dec;
  logic                   w_on;

  assign w_idle      = (r_state == c_ST_IDLE);
  assign cmd_ready   = w_idle & ~abort;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_abort_run = abort & ~w_idle;
  assign w_rem_dec   = r_remaining - CNT_FIELD_W'(1);
  assign w_gap_dec   = r_gap - c_GAP_W'(1);

  // Prescaler is phase-aligned on every accept so each phase is full length
  led_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_div   (r_div_lat),
    .o_phase (w_phase),
    .o_tick  (w_tick)
  );

  // Sequencer FSM: accept, ON/OFF blinking, looped gap, abort and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_remaining <= '0;
      r_gap       <= '0;
      r_cnt_lat   <= '0;
      r_div_lat   <= '0;
      r_loop_lat  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort_run) begin
        // Abort discards the running command entirely
        r_state     <= c_ST_IDLE;
        r_remaining <= '0;
        r_gap       <= '0;
        r_cnt_lat   <= '0;
        r_div_lat   <= '0;
        r_loop_lat  <= 1'b0;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (w_accept) begin
              r_cnt_lat   <= cmd_count;
              r_div_lat   <= cmd_div;
              r_loop_lat  <= cmd_loop;
              r_remaining <= cmd_count;
              if (cmd_count == '0) begin
                // Nothing to blink: complete immediately
                r_done <= 1'b1;
              end else begin
                r_state <= c_ST_ON;
              end
            end
          end
          c_ST_ON: begin
            if (w_tick) begin
              r_state <= c_ST_OFF;
            end
          end
          c_ST_OFF: begin
            if (w_tick) begin
              r_remaining <= w_rem_dec;
              if (w_rem_dec != '0) begin
                r_state <= c_ST_ON;
              end else if (r_loop_lat) begin
                r_state <= c_ST_GAP;
                r_gap   <= c_GAP_W'(GAP_TICKS);
              end else begin
                r_state <= c_ST_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          c_ST_GAP: begin
            if (w_tick) begin
              r_gap <= w_gap_dec;
              if (w_gap_dec == '0) begin
                // Start the next burst with the original blink count
                r_state     <= c_ST_ON;
                r_remaining <= r_cnt_lat;
              end
            end
          end
          default: begin
            r_state <= c_ST_IDLE;
          end
        endcase
      end
    end
  end

  assign w_on = (r_state == c_ST_ON);
  assign busy = ~w_idle;
  assign done = r_done;

`ifdef LED_BLINK_SEQ_DIM_EN
  logic [PWM_W-1:0] r_bright;

  // Brightness is latched with the rest of the command and dropped on abort
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bright <= '0;
    end else if (w_abort_run) begin
      r_bright <= '0;
    end else if (w_accept) begin
      r_bright <= cmd_bright;
    end
  end

  // PWM within ON: high while the low prescaler bits are below brightness
  assign led = w_on & (w_phase < r_bright);
`else
  // Brightness and PWM phase have no function in the undimmed build
  logic w_unused_dim;
  assign w_unused_dim = ^{cmd_bright, w_phase};
  assign led          = w_on;
`endif

endmodule
`default_nettype wire
